// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges load, ALU and link writebacks onto one registered
// register-file write port and tracks pending destination registers.
module regfile_wb_arbiter #(
  parameter bit         RR_EN    = 1'b1,
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        ld_valid,
  input  logic [4:0]  ld_addr,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic        lnk_valid,
  input  logic [31:0] lnk_data,
  output logic        lnk_ready,
  input  logic        rsv_valid,
  input  logic [4:0]  rsv_addr,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] busy
);

  typedef enum logic [1:0] {
    SRC_LD  = 2'd0,
    SRC_ALU = 2'd1,
    SRC_LNK = 2'd2
  } src_e;

  src_e        last_r;
  logic [1:0]  first_s;
  logic [2:0]  req_s;
  logic [2:0]  gnt_s;
  logic [4:0]  sel_addr_s;
  logic [31:0] sel_data_s;
  logic [31:0] busy_set_s;
  logic [31:0] busy_clr_s;

  // Request bits are {lnk, alu, ld}; 'first' names the slot searched first.
  function automatic logic [2:0] pick3(input logic [2:0] req, input logic [1:0] first);
    logic [2:0] rot;
    logic [2:0] g_rot;
    logic [2:0] g;
    case (first)
      2'd1:    rot = {req[0], req[2], req[1]};
      2'd2:    rot = {req[1], req[0], req[2]};
      default: rot = req;
    endcase
    g_rot = rot[0] ? 3'b001 : (rot[1] ? 3'b010 : (rot[2] ? 3'b100 : 3'b000));
    case (first)
      2'd1:    g = {g_rot[1], g_rot[0], g_rot[2]};
      2'd2:    g = {g_rot[0], g_rot[2], g_rot[1]};
      default: g = g_rot;
    endcase
    return g;
  endfunction

  // First priority slot: the requester after the last grant, or ld in fixed mode
  always_comb begin
    first_s = 2'd0;
    if (RR_EN) begin
      case (last_r)
        SRC_LD:  first_s = 2'd1;
        SRC_ALU: first_s = 2'd2;
        SRC_LNK: first_s = 2'd0;
        default: first_s = 2'd0;
      endcase
    end else begin
      first_s = 2'd0;
    end
  end

  // One-hot grant, forced idle while reset is held
  always_comb begin
    req_s = {lnk_valid, alu_valid, ld_valid};
    gnt_s = 3'b000;
    if (rst_n) begin
      gnt_s = pick3(req_s, first_s);
    end else begin
      gnt_s = 3'b000;
    end
  end

  assign ld_ready  = gnt_s[0];
  assign alu_ready = gnt_s[1];
  assign lnk_ready = gnt_s[2];

  // Destination and data of the granted requester
  always_comb begin
    sel_addr_s = 5'd0;
    sel_data_s = 32'd0;
    case (gnt_s)
      3'b001: begin
        sel_addr_s = ld_addr;
        sel_data_s = ld_data;
      end
      3'b010: begin
        sel_addr_s = alu_addr;
        sel_data_s = alu_data;
      end
      3'b100: begin
        sel_addr_s = LINK_REG;
        sel_data_s = lnk_data;
      end
      default: begin
        sel_addr_s = 5'd0;
        sel_data_s = 32'd0;
      end
    endcase
  end

  // Write port register; writes to r0 are accepted but suppressed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= 5'd0;
      wr_data <= 32'd0;
    end else if ((gnt_s != 3'b000) && (sel_addr_s != 5'd0)) begin
      wr_en   <= 1'b1;
      wr_addr <= sel_addr_s;
      wr_data <= sel_data_s;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  // Round-robin pointer remembers the last granted requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= SRC_LNK;
    end else begin
      case (gnt_s)
        3'b001:  last_r <= SRC_LD;
        3'b010:  last_r <= SRC_ALU;
        3'b100:  last_r <= SRC_LNK;
        default: last_r <= last_r;
      endcase
    end
  end

  // Scoreboard set/clear decode from reservations and committed writes
  always_comb begin
    busy_set_s = 32'd0;
    busy_clr_s = 32'd0;
    if (rsv_valid) begin
      busy_set_s[rsv_addr] = 1'b1;
    end else begin
      busy_set_s = 32'd0;
    end
    if (wr_en) begin
      busy_clr_s[wr_addr] = 1'b1;
    end else begin
      busy_clr_s = 32'd0;
    end
  end

  // Scoreboard update: a set overrides a clear, r0 is never busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 32'd0;
    end else begin
      busy <= ((busy & ~busy_clr_s) | busy_set_s) & 32'hFFFF_FFFE;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic
// against a behavioural model, on a round-robin and a fixed-priority instance.
module tb_regfile_wb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        alu_valid [2];
  logic [4:0]  alu_addr  [2];
  logic [31:0] alu_data  [2];
  logic        alu_ready [2];
  logic        ld_valid  [2];
  logic [4:0]  ld_addr   [2];
  logic [31:0] ld_data   [2];
  logic        ld_ready  [2];
  logic        lnk_valid [2];
  logic [31:0] lnk_data  [2];
  logic        lnk_ready [2];
  logic        rsv_valid [2];
  logic [4:0]  rsv_addr  [2];
  logic        wr_en     [2];
  logic [4:0]  wr_addr   [2];
  logic [31:0] wr_data   [2];
  logic [31:0] busy      [2];

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.RR_EN(1'b1), .LINK_REG(5'd31)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid[0]), .alu_addr(alu_addr[0]), .alu_data(alu_data[0]), .alu_ready(alu_ready[0]),
    .ld_valid(ld_valid[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0]), .ld_ready(ld_ready[0]),
    .lnk_valid(lnk_valid[0]), .lnk_data(lnk_data[0]), .lnk_ready(lnk_ready[0]),
    .rsv_valid(rsv_valid[0]), .rsv_addr(rsv_addr[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .busy(busy[0])
  );

  regfile_wb_arbiter #(.RR_EN(1'b0), .LINK_REG(5'd31)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid[1]), .alu_addr(alu_addr[1]), .alu_data(alu_data[1]), .alu_ready(alu_ready[1]),
    .ld_valid(ld_valid[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1]), .ld_ready(ld_ready[1]),
    .lnk_valid(lnk_valid[1]), .lnk_data(lnk_data[1]), .lnk_ready(lnk_ready[1]),
    .rsv_valid(rsv_valid[1]), .rsv_addr(rsv_addr[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .busy(busy[1])
  );

  task automatic idle(input int m);
    alu_valid[m] = 1'b0; alu_addr[m] = 5'd0; alu_data[m] = 32'd0;
    ld_valid[m]  = 1'b0; ld_addr[m]  = 5'd0; ld_data[m]  = 32'd0;
    lnk_valid[m] = 1'b0; lnk_data[m] = 32'd0;
    rsv_valid[m] = 1'b0; rsv_addr[m] = 5'd0;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic pulse_reset();
    idle(0);
    idle(1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [2:0] rv;
    idle(0);
    idle(1);
    rst_n = 1'b0;
    for (int m = 0; m < 2; m++) begin
      ld_valid[m] = 1'b1; alu_valid[m] = 1'b1; lnk_valid[m] = 1'b1;
    end
    #2;
    for (int m = 0; m < 2; m++) begin
      rv = {lnk_ready[m], alu_ready[m], ld_ready[m]};
      checks++; if (rv !== 3'b000) begin errors++; $display("FAIL reset_ready inst%0d got %b want 000", m, rv); end
      checks++; if (wr_en[m] !== 1'b0) begin errors++; $display("FAIL reset_wr_en inst%0d got %b want 0", m, wr_en[m]); end
      checks++; if (wr_addr[m] !== 5'd0) begin errors++; $display("FAIL reset_wr_addr inst%0d got %0d want 0", m, wr_addr[m]); end
      checks++; if (wr_data[m] !== 32'd0) begin errors++; $display("FAIL reset_wr_data inst%0d got %h want 0", m, wr_data[m]); end
      checks++; if (busy[m] !== 32'd0) begin errors++; $display("FAIL reset_busy inst%0d got %h want 0", m, busy[m]); end
    end
    @(posedge clk);
    #1;
    idle(0);
    idle(1);
    rst_n = 1'b1;
  endtask

  task automatic test_alu_single();
    logic [2:0] rv;
    alu_valid[0] = 1'b1; alu_addr[0] = 5'd5; alu_data[0] = 32'h0000_00AA;
    #1;
    rv = {lnk_ready[0], alu_ready[0], ld_ready[0]};
    checks++; if (rv !== 3'b010) begin errors++; $display("FAIL alu_single_ready got %b want 010", rv); end
    @(posedge clk); #1;
    alu_valid[0] = 1'b0;
    checks++; if (wr_en[0] !== 1'b1) begin errors++; $display("FAIL alu_single_wr_en got %b want 1", wr_en[0]); end
    checks++; if (wr_addr[0] !== 5'd5) begin errors++; $display("FAIL alu_single_wr_addr got %0d want 5", wr_addr[0]); end
    checks++; if (wr_data[0] !== 32'h0000_00AA) begin errors++; $display("FAIL alu_single_wr_data got %h want 000000aa", wr_data[0]); end
    @(posedge clk); #1;
    checks++; if (wr_en[0] !== 1'b0) begin errors++; $display("FAIL alu_single_idle_wr_en got %b want 0", wr_en[0]); end
  endtask

  task automatic test_rr_order();
    logic [4:0]  ea [3];
    logic [31:0] ed [3];
    logic [2:0]  rv;
    logic [2:0]  want;
    pulse_reset();
    ea[0] = 5'd10; ea[1] = 5'd11; ea[2] = 5'd31;
    ed[0] = 32'h1111_1111; ed[1] = 32'h2222_2222; ed[2] = 32'h3333_3333;
    ld_valid[0] = 1'b1; ld_addr[0] = ea[0]; ld_data[0] = ed[0];
    alu_valid[0] = 1'b1; alu_addr[0] = ea[1]; alu_data[0] = ed[1];
    lnk_valid[0] = 1'b1; lnk_data[0] = ed[2];
    for (int k = 0; k < 3; k++) begin
      #1;
      want = 3'b001 << k;
      rv = {lnk_ready[0], alu_ready[0], ld_ready[0]};
      checks++; if (rv !== want) begin errors++; $display("FAIL rr_order_ready step%0d got %b want %b", k, rv, want); end
      @(posedge clk); #1;
      if (k == 0) ld_valid[0] = 1'b0;
      else if (k == 1) alu_valid[0] = 1'b0;
      else lnk_valid[0] = 1'b0;
      checks++; if (wr_en[0] !== 1'b1) begin errors++; $display("FAIL rr_order_wr_en step%0d got %b want 1", k, wr_en[0]); end
      checks++; if (wr_addr[0] !== ea[k]) begin errors++; $display("FAIL rr_order_wr_addr step%0d got %0d want %0d", k, wr_addr[0], ea[k]); end
      checks++; if (wr_data[0] !== ed[k]) begin errors++; $display("FAIL rr_order_wr_data step%0d got %h want %h", k, wr_data[0], ed[k]); end
    end
  endtask

  task automatic test_fixed_prio();
    logic [2:0] rv;
    pulse_reset();
    ld_valid[1] = 1'b1; ld_addr[1] = 5'd12; ld_data[1] = 32'h44;
    alu_valid[1] = 1'b1; alu_addr[1] = 5'd13; alu_data[1] = 32'h55;
    #1;
    rv = {lnk_ready[1], alu_ready[1], ld_ready[1]};
    checks++; if (rv !== 3'b001) begin errors++; $display("FAIL fixed_first got %b want 001", rv); end
    @(posedge clk); #1;
    ld_addr[1] = 5'd14; ld_data[1] = 32'h66;
    checks++; if (wr_addr[1] !== 5'd12) begin errors++; $display("FAIL fixed_first_wr_addr got %0d want 12", wr_addr[1]); end
    #1;
    rv = {lnk_ready[1], alu_ready[1], ld_ready[1]};
    checks++; if (rv !== 3'b001) begin errors++; $display("FAIL fixed_ld_again got %b want 001", rv); end
    @(posedge clk); #1;
    ld_valid[1] = 1'b0;
    checks++; if (wr_addr[1] !== 5'd14) begin errors++; $display("FAIL fixed_second_wr_addr got %0d want 14", wr_addr[1]); end
    #1;
    rv = {lnk_ready[1], alu_ready[1], ld_ready[1]};
    checks++; if (rv !== 3'b010) begin errors++; $display("FAIL fixed_alu got %b want 010", rv); end
    @(posedge clk); #1;
    alu_valid[1] = 1'b0;
    checks++; if (wr_data[1] !== 32'h55) begin errors++; $display("FAIL fixed_alu_wr_data got %h want 55", wr_data[1]); end
  endtask

  task automatic test_addr_zero();
    alu_valid[0] = 1'b1; alu_addr[0] = 5'd0; alu_data[0] = 32'hFFFF_FFFF;
    #1;
    checks++; if (alu_ready[0] !== 1'b1) begin errors++; $display("FAIL addr_zero_ready got %b want 1", alu_ready[0]); end
    @(posedge clk); #1;
    alu_valid[0] = 1'b0;
    checks++; if (wr_en[0] !== 1'b0) begin errors++; $display("FAIL addr_zero_wr_en got %b want 0", wr_en[0]); end
  endtask

  task automatic test_scoreboard();
    pulse_reset();
    rsv_valid[0] = 1'b1; rsv_addr[0] = 5'd7;
    @(posedge clk); #1;
    rsv_valid[0] = 1'b0;
    checks++; if (busy[0][7] !== 1'b1) begin errors++; $display("FAIL sb_set got %b want 1", busy[0][7]); end
    @(posedge clk); #1;
    checks++; if (busy[0][7] !== 1'b1) begin errors++; $display("FAIL sb_hold got %b want 1", busy[0][7]); end
    ld_valid[0] = 1'b1; ld_addr[0] = 5'd7; ld_data[0] = 32'h77;
    @(posedge clk); #1;
    ld_valid[0] = 1'b0;
    checks++; if ((wr_en[0] !== 1'b1) || (wr_addr[0] !== 5'd7)) begin errors++; $display("FAIL sb_write got en=%b addr=%0d want en=1 addr=7", wr_en[0], wr_addr[0]); end
    checks++; if (busy[0][7] !== 1'b1) begin errors++; $display("FAIL sb_busy_during_write got %b want 1", busy[0][7]); end
    @(posedge clk); #1;
    checks++; if (busy[0][7] !== 1'b0) begin errors++; $display("FAIL sb_clear got %b want 0", busy[0][7]); end
    rsv_valid[0] = 1'b1; rsv_addr[0] = 5'd7;
    @(posedge clk); #1;
    rsv_valid[0] = 1'b0;
    ld_valid[0] = 1'b1; ld_addr[0] = 5'd7; ld_data[0] = 32'h78;
    @(posedge clk); #1;
    ld_valid[0] = 1'b0;
    rsv_valid[0] = 1'b1; rsv_addr[0] = 5'd7;
    @(posedge clk); #1;
    rsv_addr[0] = 5'd0;
    checks++; if (busy[0][7] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b want 1", busy[0][7]); end
    @(posedge clk); #1;
    rsv_valid[0] = 1'b0;
    checks++; if (busy[0] !== 32'h0000_0080) begin errors++; $display("FAIL sb_r0_ignored got %h want 00000080", busy[0]); end
  endtask

  task automatic test_reset_mid();
    logic [2:0] rv;
    alu_valid[0] = 1'b1; alu_addr[0] = 5'd3; alu_data[0] = 32'h33;
    #1;
    checks++; if (alu_ready[0] !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", alu_ready[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    rv = {lnk_ready[0], alu_ready[0], ld_ready[0]};
    checks++; if (wr_en[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_wr_en got %b want 0", wr_en[0]); end
    checks++; if (busy[0] !== 32'd0) begin errors++; $display("FAIL rst_mid_busy got %h want 0", busy[0]); end
    checks++; if (rv !== 3'b000) begin errors++; $display("FAIL rst_mid_ready_low got %b want 000", rv); end
    alu_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++; if (wr_en[0] !== 1'b0) begin errors++; $display("FAIL rst_mid_no_write cyc%0d got %b want 0", k, wr_en[0]); end
    end
  endtask

  // Randomized traffic against a model built from the arbitration rules.
  task automatic test_random(input int m, input int cycles);
    logic        v [3];
    logic [4:0]  a [3];
    logic [31:0] d [3];
    logic        rv_v;
    logic [4:0]  rv_a;
    logic [31:0] mbusy;
    logic        men;
    logic [4:0]  maddr;
    logic [31:0] mdata;
    logic [4:0]  da;
    logic [2:0]  want;
    logic [2:0]  got;
    int          last;
    int          g;
    int          idx;
    bit          rr;
    rr = (m == 0);
    pulse_reset();
    last = 2; mbusy = 32'd0; men = 1'b0; maddr = 5'd0; mdata = 32'd0;
    for (int i = 0; i < 3; i++) begin v[i] = 1'b0; a[i] = 5'd0; d[i] = 32'd0; end
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!v[i] && ($urandom_range(0, 2) != 0)) begin
          v[i] = 1'b1;
          a[i] = 5'($urandom_range(0, 31));
          d[i] = $urandom;
        end
      end
      rv_v = 1'($urandom_range(0, 1));
      rv_a = 5'($urandom_range(0, 31));
      ld_valid[m] = v[0]; ld_addr[m] = a[0]; ld_data[m] = d[0];
      alu_valid[m] = v[1]; alu_addr[m] = a[1]; alu_data[m] = d[1];
      lnk_valid[m] = v[2]; lnk_data[m] = d[2];
      rsv_valid[m] = rv_v; rsv_addr[m] = rv_a;
      #1;
      g = -1;
      for (int k = 0; k < 3; k++) begin
        idx = rr ? ((last + 1 + k) % 3) : k;
        if ((g < 0) && v[idx]) g = idx;
      end
      want = (g < 0) ? 3'b000 : (3'b001 << g);
      got = {lnk_ready[m], alu_ready[m], ld_ready[m]};
      checks++; if (got !== want) begin errors++; $display("FAIL rand_ready inst%0d cyc%0d got %b want %b", m, c, got, want); end
      if (men) mbusy[maddr] = 1'b0;
      if (rv_v && (rv_a != 5'd0)) mbusy[rv_a] = 1'b1;
      if (g >= 0) begin
        da = (g == 2) ? 5'd31 : a[g];
        men = (da != 5'd0);
        if (da != 5'd0) begin maddr = da; mdata = d[g]; end
        last = g;
      end else begin
        men = 1'b0;
      end
      @(posedge clk); #1;
      if (g >= 0) v[g] = 1'b0;
      checks++; if (wr_en[m] !== men) begin errors++; $display("FAIL rand_wr_en inst%0d cyc%0d got %b want %b", m, c, wr_en[m], men); end
      checks++; if (wr_addr[m] !== maddr) begin errors++; $display("FAIL rand_wr_addr inst%0d cyc%0d got %0d want %0d", m, c, wr_addr[m], maddr); end
      checks++; if (wr_data[m] !== mdata) begin errors++; $display("FAIL rand_wr_data inst%0d cyc%0d got %h want %h", m, c, wr_data[m], mdata); end
      checks++; if (busy[m] !== mbusy) begin errors++; $display("FAIL rand_busy inst%0d cyc%0d got %h want %h", m, c, busy[m], mbusy); end
    end
    idle(m);
  endtask

  initial begin
    test_reset();
    test_alu_single();
    test_rr_order();
    test_fixed_prio();
    test_addr_zero();
    test_scoreboard();
    test_reset_mid();
    test_random(0, 400);
    test_random(1, 400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin grant, 0 = fixed priority ld > alu > lnk.
REQ-002 Parameter: LINK_REG, default 31, destination register for link (jal) writes.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 alu_valid  input  1  ALU writeback request.
REQ-006 alu_addr  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU result.
REQ-008 alu_ready  output  1  ALU request accepted this cycle.
REQ-009 ld_valid / ld_addr / ld_data  input  1 / 5 / 32  load writeback request, destination, data.
REQ-010 ld_ready  output  1  load request accepted this cycle.
REQ-011 lnk_valid / lnk_data  input  1 / 32  link request and return address (pc+4).
REQ-012 lnk_ready  output  1  link request accepted this cycle.
REQ-013 rsv_valid / rsv_addr  input  1 / 5  issue stage reserves a destination register.
REQ-014 wr_en / wr_addr / wr_data  output  1 / 5 / 32  single register-file write port, registered.
REQ-015 busy  output  32  scoreboard: bit r = write to register r pending.

Function
REQ-016 Handshake: a request is accepted in a cycle where its valid and ready are both 1; a requester SHALL hold valid, addr and data stable until accepted.
REQ-017 At most one ready SHALL be 1 per cycle; ready_i is combinational from the valid inputs and the grant pointer, and is 1 only if valid_i is 1.
REQ-018 RR_EN=1: priority order starts at the requester after the last granted one, cycling ld -> alu -> lnk -> ld; pointer updates only on a grant.
REQ-019 RR_EN=0: grant goes to highest-priority valid requester, ld > alu > lnk; pointer unused.
REQ-020 Latency: a request accepted in cycle N SHALL appear on wr_en/wr_addr/wr_data in cycle N+1 (one register stage); one write per cycle, back-to-back accepts allowed.
REQ-021 Link requests SHALL write to LINK_REG with lnk_data.
REQ-022 Accepted request with destination 0: accepted normally, but wr_en SHALL be 0 in cycle N+1 (register 0 never written).
REQ-023 wr_en SHALL be 0 in any cycle following a cycle with no accept; wr_addr/wr_data hold last value when wr_en=0.
REQ-024 Scoreboard set: rsv_valid=1 with rsv_addr=r, r!=0, sets busy[r] at next edge.
REQ-025 Scoreboard clear: a cycle with wr_en=1, wr_addr=r clears busy[r] at next edge.
REQ-026 Simultaneous set and clear of the same register: set wins (busy[r] stays 1).
REQ-027 Reservation of an already-busy register: busy stays 1; no counting, single clear suffices.
REQ-028 busy[0] SHALL always be 0; rsv_addr=0 ignored.
REQ-029 Clear of a register not busy: no effect; no error signalled.

Reset
REQ-030 rst_n=0 SHALL asynchronously force wr_en=0, wr_addr=0, wr_data=0, busy=0, grant pointer = lnk (first round-robin priority is ld).
REQ-031 While rst_n=0, all ready outputs SHALL be 0.
REQ-032 Reset mid-operation: a request accepted in the cycle before reset assertion is discarded; no write appears after reset release.
REQ-033 First posedge after rst_n deassertion operates normally (no dead cycle).

Verification
REQ-034 Reset then single ALU request addr=5 data=0x0000_00AA -> alu_ready=1 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0x0000_00AA.
REQ-035 RR_EN=1, ld, alu, lnk all valid held 3 cycles -> grants ld, alu, lnk in that order; writes follow one cycle each; lnk write to 31.
REQ-036 RR_EN=0, ld and alu valid for 2 cycles -> ld granted first, alu second; alu never granted while ld valid.
REQ-037 ALU request addr=0 data=0xFFFF_FFFF -> alu_ready=1, next cycle wr_en=0.
REQ-038 rsv addr=7, later ld write addr=7 -> busy[7]=1 until edge after wr_en cycle; rsv addr=7 in same cycle as wr_en addr=7 -> busy[7] remains 1.
REQ-039 Accept alu addr=3, assert rst_n=0 before next edge -> wr_en=0, busy=0 immediately; no write to 3 after release.
